// File: rtl/ipif_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipif_master_pkg
// Description : Shared constants and types for the IPIF command master:
//               FSM state encoding, CE vector width, index-to-address shift.
// Revision    : 1.0 - initial release
// ============================================================================
package ipif_master_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Bus geometry
  localparam int CE_WIDTH   = 32;
  localparam int REG_IDX_W  = 5;
  localparam int ADDR_SHIFT = 2;   // registers are 32-bit words: byte addr = idx*4

  // Latched command captured at acceptance
  typedef struct packed {
    logic                 rnw;
    logic [REG_IDX_W-1:0] idx;
    logic [31:0]          data;
    logic [3:0]           be;
  } cmd_t;

  // Byte address of a register index
  function automatic logic [31:0] reg_to_addr(input logic [REG_IDX_W-1:0] idx);
    return 32'(idx) << ADDR_SHIFT;
  endfunction

endpackage : ipif_master_pkg
`default_nettype wire

// File: rtl/ipif_ce_decode.sv
`default_nettype none
// ============================================================================
// Module      : ipif_ce_decode
// Description : Register index + enable to one-hot CE vector. Bit 0 of the
//               [0:31] vector (the MSB) selects register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ipif_ce_decode
  import ipif_master_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [0:CE_WIDTH-1]  ce
);

  // One comparator per CE line; ascending range puts register 0 leftmost
  generate
    for (genvar i = 0; i < CE_WIDTH; i++) begin : g_ce
      assign ce[i] = en && (idx == REG_IDX_W'(i));
    end
  endgenerate

endmodule : ipif_ce_decode
`default_nettype wire

// File: rtl/ipif_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : ipif_cmd_master
// Description : Converts a valid/ready command stream into single IPIF
//               register accesses (one CE line per register) and returns a
//               valid/ready response with read data, error and timeout.
//               C_NUM_REG : 1..32, C_TIMEOUT : 2..255.
// Revision    : 1.0 - initial release
// ============================================================================
module ipif_cmd_master
  import ipif_master_pkg::*;
#(
  parameter int C_NUM_REG = 32,
  parameter int C_TIMEOUT = 16
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Reset,
  // command channel
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic                 Cmd_RNW,
  input  logic [4:0]           Cmd_Reg,
  input  logic [31:0]          Cmd_Data,
  input  logic [3:0]           Cmd_BE,
  // response channel
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [31:0]          Rsp_Data,
  output logic                 Rsp_Error,
  output logic                 Rsp_Timeout,
  // IPIF master side
  output logic [0:0]           Bus2IP_CS,
  output logic                 Bus2IP_RNW,
  output logic [0:31]          Bus2IP_Addr,
  output logic [0:31]          Bus2IP_Data,
  output logic [0:3]           Bus2IP_BE,
  output logic [0:CE_WIDTH-1]  Bus2IP_RdCE,
  output logic [0:CE_WIDTH-1]  Bus2IP_WrCE,
  input  logic [0:31]          IP2Bus_Data,
  input  logic                 IP2Bus_RdAck,
  input  logic                 IP2Bus_WrAck,
  input  logic                 IP2Bus_Error
);

  // Widened so that C_NUM_REG = 32 compares correctly against a 5-bit index
  localparam logic [5:0] c_num_reg = 6'(C_NUM_REG);
  // Counter value during the last ACCESS cycle before abort
  localparam logic [7:0] c_tmo_last = 8'(C_TIMEOUT - 1);

  logic [1:0]          r_state;
  cmd_t                r_cmd;
  logic [7:0]          r_cnt;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_err;
  logic                r_rsp_tmo;

  logic                w_access;
  logic                w_idx_ok;
  logic                w_ack;
  logic                w_expire;
  logic [0:CE_WIDTH-1] w_ce;
  logic [31:0]         w_addr;

  assign w_access = (r_state == ST_ACCESS);
  assign w_idx_ok = ({1'b0, Cmd_Reg} < c_num_reg);
  // Only the ack matching the access direction terminates it
  assign w_ack    = w_access && (r_cmd.rnw ? IP2Bus_RdAck : IP2Bus_WrAck);
  assign w_expire = w_access && (r_cnt == c_tmo_last);
  assign w_addr   = reg_to_addr(r_cmd.idx);

  // One-hot CE generation, only enabled while an access is in flight
  ipif_ce_decode u_ce_decode (
    .idx (r_cmd.idx),
    .en  (w_access),
    .ce  (w_ce)
  );

  // Main FSM: command capture, access termination and response handshake
  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_tmo  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Cmd_Valid) begin
            r_cmd.rnw  <= Cmd_RNW;
            r_cmd.idx  <= Cmd_Reg;
            r_cmd.data <= Cmd_Data;
            r_cmd.be   <= Cmd_BE;
            if (w_idx_ok) begin
              r_state <= ST_ACCESS;
            end else begin
              // Out-of-range index: answer immediately, never touch the bus
              r_state    <= ST_RESP;
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
              r_rsp_tmo  <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so an ack on the expiry cycle still wins
          if (w_ack) begin
            r_state    <= ST_RESP;
            r_rsp_data <= r_cmd.rnw ? IP2Bus_Data : 32'd0;
            r_rsp_err  <= IP2Bus_Error;
            r_rsp_tmo  <= 1'b0;
          end else if (w_expire) begin
            r_state    <= ST_RESP;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_tmo  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (Rsp_Ready) begin
            r_state    <= ST_IDLE;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_tmo  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Timeout counter: zero on ACCESS entry, counts completed ACCESS cycles
  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      r_cnt <= '0;
    end else if (w_access) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Handshake outputs
  assign Cmd_Ready   = (r_state == ST_IDLE);
  assign Rsp_Valid   = (r_state == ST_RESP);
  assign Rsp_Data    = r_rsp_data;
  assign Rsp_Error   = r_rsp_err;
  assign Rsp_Timeout = r_rsp_tmo;

  // Bus outputs decode straight from state, so reset clears them immediately
  assign Bus2IP_CS   = w_access;
  assign Bus2IP_RNW  = w_access && r_cmd.rnw;
  assign Bus2IP_Addr = w_access ? w_addr : '0;
  assign Bus2IP_Data = (w_access && !r_cmd.rnw) ? r_cmd.data : '0;
  assign Bus2IP_BE   = w_access ? r_cmd.be : '0;
  assign Bus2IP_RdCE = r_cmd.rnw ? w_ce : '0;
  assign Bus2IP_WrCE = r_cmd.rnw ? '0 : w_ce;

endmodule : ipif_cmd_master
`default_nettype wire

// File: tb/tb_ipif_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipif_cmd_master
// Description : Self-checking bench for ipif_cmd_master: a table of
//               single-command vectors plus hand sequences for response
//               back-pressure, back-to-back accept and reset mid-access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipif_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic        Cmd_RNW = 1'b0;
  logic [4:0]  Cmd_Reg = '0;
  logic [31:0] Cmd_Data = '0;
  logic [3:0]  Cmd_BE = '0;
  logic        Rsp_Valid;
  logic        Rsp_Ready = 1'b0;
  logic [31:0] Rsp_Data;
  logic        Rsp_Error;
  logic        Rsp_Timeout;
  logic [0:0]  Bus2IP_CS;
  logic        Bus2IP_RNW;
  logic [0:31] Bus2IP_Addr;
  logic [0:31] Bus2IP_Data;
  logic [0:3]  Bus2IP_BE;
  logic [0:31] Bus2IP_RdCE;
  logic [0:31] Bus2IP_WrCE;
  logic [0:31] IP2Bus_Data = '1;
  logic        IP2Bus_RdAck = 1'b0;
  logic        IP2Bus_WrAck = 1'b0;
  logic        IP2Bus_Error = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ipif_cmd_master #(.C_NUM_REG(20), .C_TIMEOUT(16)) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .Cmd_Valid    (Cmd_Valid),
    .Cmd_Ready    (Cmd_Ready),
    .Cmd_RNW      (Cmd_RNW),
    .Cmd_Reg      (Cmd_Reg),
    .Cmd_Data     (Cmd_Data),
    .Cmd_BE       (Cmd_BE),
    .Rsp_Valid    (Rsp_Valid),
    .Rsp_Ready    (Rsp_Ready),
    .Rsp_Data     (Rsp_Data),
    .Rsp_Error    (Rsp_Error),
    .Rsp_Timeout  (Rsp_Timeout),
    .Bus2IP_CS    (Bus2IP_CS),
    .Bus2IP_RNW   (Bus2IP_RNW),
    .Bus2IP_Addr  (Bus2IP_Addr),
    .Bus2IP_Data  (Bus2IP_Data),
    .Bus2IP_BE    (Bus2IP_BE),
    .Bus2IP_RdCE  (Bus2IP_RdCE),
    .Bus2IP_WrCE  (Bus2IP_WrCE),
    .IP2Bus_Data  (IP2Bus_Data),
    .IP2Bus_RdAck (IP2Bus_RdAck),
    .IP2Bus_WrAck (IP2Bus_WrAck),
    .IP2Bus_Error (IP2Bus_Error)
  );

  typedef struct {
    logic        rnw;
    logic [4:0]  rg;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_at;    // ACCESS cycle with matching ack (0 = never)
    int          wrong_at;  // ACCESS cycle with the opposite ack (0 = never)
    logic [31:0] rdata;     // slave data presented on the ack cycle
    logic        serr;      // slave error presented on the ack cycle
    logic [31:0] e_rdce;
    logic [31:0] e_wrce;
    logic [31:0] e_addr;
    logic [31:0] e_bdata;
    int          e_acc;     // expected number of ACCESS cycles
    logic [31:0] e_rsp;
    logic        e_err;
    logic        e_to;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one command, play the slave, then check and consume the response
  task automatic run_vec(input int n, input vec_t v);
    int    acc;
    bit    done;
    bit    strobe_ok;
    string tag;
    tag = $sformatf("v%0d", n);
    acc = 0;
    done = 0;
    strobe_ok = 1;
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_RNW = v.rnw; Cmd_Reg = v.rg; Cmd_Data = v.wdata; Cmd_BE = v.be;
    @(posedge clk); #1;
    Cmd_Valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (Rsp_Valid) begin
        done = 1;
      end else begin
        if (Bus2IP_CS[0]) begin
          acc++;
          if (Bus2IP_RdCE !== v.e_rdce || Bus2IP_WrCE !== v.e_wrce ||
              Bus2IP_Addr !== v.e_addr || Bus2IP_Data !== v.e_bdata ||
              Bus2IP_BE !== v.be || Bus2IP_RNW !== v.rnw) begin
            if (strobe_ok)
              $display("FAIL %s_strobe: cyc %0d rdce=%h wrce=%h addr=%h data=%h be=%h", tag, acc,
                       Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE);
            strobe_ok = 0;
          end
          if (acc == v.ack_at) begin
            if (v.rnw) IP2Bus_RdAck = 1'b1; else IP2Bus_WrAck = 1'b1;
            IP2Bus_Data  = v.rdata;
            IP2Bus_Error = v.serr;
          end else if (acc == v.wrong_at) begin
            if (v.rnw) IP2Bus_WrAck = 1'b1; else IP2Bus_RdAck = 1'b1;
          end
        end else if (Bus2IP_RdCE !== '0 || Bus2IP_WrCE !== '0) begin
          strobe_ok = 0;
          $display("FAIL %s_ce_without_cs: rdce=%h wrce=%h", tag, Bus2IP_RdCE, Bus2IP_WrCE);
        end
        @(posedge clk); #1;
        IP2Bus_RdAck = 1'b0; IP2Bus_WrAck = 1'b0; IP2Bus_Error = 1'b0; IP2Bus_Data = '1;
      end
    end
    total++;
    if (!strobe_ok) bad++;
    check({tag, "_rsp_seen"}, 32'(done), 32'd1);
    check({tag, "_access_cycles"}, acc, v.e_acc);
    check({tag, "_rsp_data"}, Rsp_Data, v.e_rsp);
    check({tag, "_rsp_err"}, 32'(Rsp_Error), 32'(v.e_err));
    check({tag, "_rsp_to"}, 32'(Rsp_Timeout), 32'(v.e_to));
    check({tag, "_bus_idle_in_resp"}, 32'(Bus2IP_CS[0]) | 32'(|Bus2IP_RdCE) | 32'(|Bus2IP_WrCE), 32'd0);
    Rsp_Ready = 1'b1;
    @(posedge clk); #1;
    Rsp_Ready = 1'b0;
    check({tag, "_after_hs"}, {30'd0, Rsp_Valid, Cmd_Ready}, 32'd1);
  endtask

  initial begin
    bit stable_ok;
    bit no_rsp;

    // rnw rg wdata be ack wrong rdata serr | rdce wrce addr bdata acc rsp err to
    vecs[0] = '{1'b0, 5'd6,  32'd20,         4'hF, 2,  0, 32'h7777_7777, 1'b0,
                32'h0,         32'h0200_0000, 32'd24, 32'd20,         2,  32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'h0,          4'hF, 1,  0, 32'h0000_0001, 1'b0,
                32'h8000_0000, 32'h0,         32'd0,  32'h0,          1,  32'h1,         1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd19, 32'h0,          4'hF, 0,  0, 32'hDEAD_BEEF, 1'b0,
                32'h0000_1000, 32'h0,         32'd76, 32'h0,          16, 32'h0,         1'b1, 1'b1};
    vecs[3] = '{1'b1, 5'd3,  32'h0,          4'hC, 3,  1, 32'h1234_5678, 1'b1,
                32'h1000_0000, 32'h0,         32'd12, 32'h0,          3,  32'h1234_5678, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 5'd20, 32'h0,          4'hF, 0,  0, 32'h0,         1'b0,
                32'h0,         32'h0,         32'd0,  32'h0,          0,  32'h0,         1'b1, 1'b0};
    vecs[5] = '{1'b0, 5'd31, 32'hA5A5_5A5A,  4'h3, 0,  0, 32'h0,         1'b0,
                32'h0,         32'h0,         32'd0,  32'h0,          0,  32'h0,         1'b1, 1'b0};
    vecs[6] = '{1'b1, 5'd5,  32'h0,          4'hF, 16, 0, 32'hCAFE_F00D, 1'b0,
                32'h0400_0000, 32'h0,         32'd20, 32'h0,          16, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 5'd10, 32'h0000_FFFF,  4'h5, 15, 0, 32'h5555_5555, 1'b0,
                32'h0,         32'h0020_0000, 32'd40, 32'h0000_FFFF,  15, 32'h0,         1'b0, 1'b0};
    vecs[8] = '{1'b0, 5'd1,  32'h1111_2222,  4'hA, 2,  1, 32'h0,         1'b1,
                32'h0,         32'h4000_0000, 32'd4,  32'h1111_2222,  2,  32'h0,         1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    check("rst_rsp", {29'd0, Rsp_Valid, Rsp_Error, Rsp_Timeout}, 32'd0);
    check("rst_bus", 32'(Bus2IP_CS[0]) | 32'(Bus2IP_RNW) | 32'(|Bus2IP_RdCE) | 32'(|Bus2IP_WrCE), 32'd0);
    check("rst_addr_data", Bus2IP_Addr | Bus2IP_Data | 32'(Bus2IP_BE) | Rsp_Data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(Cmd_Ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Response back-pressure with a second command already waiting
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_RNW = 1'b1; Cmd_Reg = 5'd2; Cmd_Data = '0; Cmd_BE = 4'hF;
    @(posedge clk); #1;
    Cmd_RNW = 1'b0; Cmd_Reg = 5'd7; Cmd_Data = 32'd99; Cmd_BE = 4'h9;
    IP2Bus_RdAck = 1'b1; IP2Bus_Data = 32'h0000_0055;
    @(posedge clk); #1;
    IP2Bus_RdAck = 1'b0; IP2Bus_Data = '1;
    check("bp_rsp_valid", 32'(Rsp_Valid), 32'd1);
    stable_ok = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (Rsp_Valid !== 1'b1 || Rsp_Data !== 32'h55 || Rsp_Error !== 1'b0 ||
          Rsp_Timeout !== 1'b0 || Cmd_Ready !== 1'b0 || Bus2IP_CS[0] !== 1'b0 ||
          Bus2IP_WrCE !== '0 || Bus2IP_RdCE !== '0)
        stable_ok = 0;
    end
    check("bp_stable", 32'(stable_ok), 32'd1);
    Rsp_Ready = 1'b1;
    @(posedge clk); #1;
    Rsp_Ready = 1'b0;
    check("b2b_idle_gap", {29'd0, Cmd_Ready, Rsp_Valid, Bus2IP_CS[0]}, 32'd4);
    @(posedge clk); #1;
    Cmd_Valid = 1'b0;
    check("b2b_wrce", Bus2IP_WrCE, 32'h0100_0000);
    check("b2b_wdata", Bus2IP_Data, 32'd99);
    IP2Bus_WrAck = 1'b1;
    @(posedge clk); #1;
    IP2Bus_WrAck = 1'b0;
    check("b2b_rsp", {30'd0, Rsp_Valid, Rsp_Error}, 32'd2);
    Rsp_Ready = 1'b1;
    @(posedge clk); #1;
    Rsp_Ready = 1'b0;

    // Reset in the middle of an access
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_RNW = 1'b0; Cmd_Reg = 5'd4; Cmd_Data = 32'h1; Cmd_BE = 4'hF;
    @(posedge clk); #1;
    Cmd_Valid = 1'b0;
    @(posedge clk); #1;
    check("mid_cs_before_rst", 32'(Bus2IP_CS[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_bus_low", 32'(Bus2IP_CS[0]) | 32'(|Bus2IP_WrCE) | 32'(|Bus2IP_RdCE), 32'd0);
    check("mid_rst_no_rsp", 32'(Rsp_Valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    no_rsp = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (Rsp_Valid !== 1'b0 || Bus2IP_CS[0] !== 1'b0) no_rsp = 0;
    end
    check("mid_rst_discarded", 32'(no_rsp), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_ipif_cmd_master
`default_nettype wire
